// File: rtl/core_pkg.sv
// Core-wide shared constants.
package core_pkg;
    localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/core_wb_pkg.sv
// Writeback requester indices and the per-requester payload type.
package core_wb_pkg;
    localparam int NUM_WB_REQ = 3;
    localparam int WB_REQ_LSU = 0;
    localparam int WB_REQ_MDU = 1;
    localparam int WB_REQ_EXU = 2;

    typedef struct packed {
        logic [4:0]                     rd;
        logic [core_pkg::DATA_WIDTH-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/core_wb_scoreboard_ctrl_if.sv
// Decode hazard, writeback request and register-file write signals.
interface core_wb_scoreboard_ctrl_if #(
    parameter int NUM_REQ = core_wb_pkg::NUM_WB_REQ
);
    localparam int DW = core_pkg::DATA_WIDTH;

    logic                    id_valid;
    logic                    id_rs1_use;
    logic                    id_rs2_use;
    logic                    id_rd_use;
    logic [4:0]              id_rs1_addr;
    logic [4:0]              id_rs2_addr;
    logic [4:0]              id_rd_addr;
    logic                    id_stall;
    logic                    id_issue;
    logic [NUM_REQ-1:0]      wb_valid;
    logic [NUM_REQ*5-1:0]    wb_rd;
    logic [NUM_REQ*DW-1:0]   wb_data;
    logic [NUM_REQ-1:0]      wb_ready;
    logic                    rf_we;
    logic [4:0]              rf_addr;
    logic [DW-1:0]           rf_data;

    modport master (
        output id_valid, id_rs1_use, id_rs2_use, id_rd_use,
               id_rs1_addr, id_rs2_addr, id_rd_addr,
               wb_valid, wb_rd, wb_data,
        input  id_stall, id_issue, wb_ready, rf_we, rf_addr, rf_data
    );

    modport slave (
        input  id_valid, id_rs1_use, id_rs2_use, id_rd_use,
               id_rs1_addr, id_rs2_addr, id_rd_addr,
               wb_valid, wb_rd, wb_data,
        output id_stall, id_issue, wb_ready, rf_we, rf_addr, rf_data
    );
endinterface

// File: rtl/core_scoreboard.sv
// 32-entry register busy scoreboard with one set, one clear and three read ports.
// Latency: set/clear visible on reads one cycle after the edge; reads are combinational.
// Backpressure: none; x0 is never reported busy.
module core_scoreboard (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic [4:0] set_addr,
    input  logic       clr_en,
    input  logic [4:0] clr_addr,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic [4:0] rd_addr,
    output logic       rs1_busy,
    output logic       rs2_busy,
    output logic       rd_busy
);
    logic [31:0] busy;

    // Set and clear target different registers by construction (WAW stalls issue).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (clr_en)
                busy[clr_addr] <= 1'b0;
            if (set_en && (set_addr != 5'd0))
                busy[set_addr] <= 1'b1;
        end
    end

    assign rs1_busy = busy[rs1_addr] & (rs1_addr != 5'd0);
    assign rs2_busy = busy[rs2_addr] & (rs2_addr != 5'd0);
    assign rd_busy  = busy[rd_addr]  & (rd_addr  != 5'd0);
endmodule

// File: rtl/core_wb_scoreboard_ctrl.sv
// Decode hazard stall plus shared register-file write port arbiter (CORE_WB_RR_EN selects round-robin).
// Latency: stall is combinational; grant -> rf_we is one cycle; busy clears the cycle rf_we is high.
// Backpressure: one requester granted per cycle via wb_ready; decode held via id_stall.
module core_wb_scoreboard_ctrl
    import core_wb_pkg::*;
#(
    parameter int NUM_REQ = NUM_WB_REQ
) (
    input  logic                      clk,
    input  logic                      rst,
    core_wb_scoreboard_ctrl_if.slave  bus
);
    localparam int DW = core_pkg::DATA_WIDTH;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic              rs1_busy, rs2_busy, rd_busy;
    logic              stall, issue;
    wb_req_t           req [NUM_REQ];
    wb_req_t           sel_req;
    logic [NUM_REQ-1:0] grant;
    logic              found;
    logic              rf_we_q;
    logic [4:0]        rf_addr_q;
    logic [DW-1:0]     rf_data_q;

    core_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue & bus.id_rd_use),
        .set_addr (bus.id_rd_addr),
        .clr_en   (rf_we_q),
        .clr_addr (rf_addr_q),
        .rs1_addr (bus.id_rs1_addr),
        .rs2_addr (bus.id_rs2_addr),
        .rd_addr  (bus.id_rd_addr),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy)
    );

    assign stall = bus.id_valid & ((bus.id_rs1_use & rs1_busy) |
                                   (bus.id_rs2_use & rs2_busy) |
                                   (bus.id_rd_use  & rd_busy));
    assign issue = bus.id_valid & ~stall;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign req[g] = {bus.wb_rd[g*5 +: 5], bus.wb_data[g*DW +: DW]};
    end

`ifdef CORE_WB_RR_EN
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] sel_idx;
    int            best;
    int            dist;

    // Pick the valid requester at the smallest rotational distance from rr_ptr.
    always_comb begin
        grant   = '0;
        sel_req = '0;
        found   = 1'b0;
        best    = NUM_REQ;
        dist    = 0;
        sel_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dist = (i >= int'(rr_ptr)) ? (i - int'(rr_ptr)) : (i + NUM_REQ - int'(rr_ptr));
            if (bus.wb_valid[i] && (dist < best)) begin
                best    = dist;
                sel_idx = PW'(i);
                sel_req = req[i];
                found   = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++)
            grant[i] = found && (sel_idx == PW'(i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (found)
            rr_ptr <= (sel_idx == PW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
    end
`else
    always_comb begin
        grant   = '0;
        sel_req = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.wb_valid[i] && !found) begin
                grant[i] = 1'b1;
                sel_req  = req[i];
                found    = 1'b1;
            end
        end
    end
`endif

    // A grant to x0 completes the handshake but never writes or clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else if (found) begin
            rf_we_q   <= (sel_req.rd != 5'd0);
            rf_addr_q <= sel_req.rd;
            rf_data_q <= sel_req.data;
        end else begin
            rf_we_q   <= 1'b0;
        end
    end

    assign bus.id_stall = stall;
    assign bus.id_issue = issue;
    assign bus.wb_ready = rst ? '0 : grant;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_addr  = rf_addr_q;
    assign bus.rf_data  = rf_data_q;
endmodule

// File: tb/tb_core_wb_scoreboard_ctrl.sv
// Scoreboard bench: reference model of busy bits, grant order and expected register writes.
module tb_core_wb_scoreboard_ctrl;
    import core_wb_pkg::*;
    localparam int N  = NUM_WB_REQ;
    localparam int DW = core_pkg::DATA_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_wb_scoreboard_ctrl_if #(.NUM_REQ(N)) bus ();
    core_wb_scoreboard_ctrl #(.NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic [4:0] a; logic [DW-1:0] d; int due; } wr_t;

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge clk) cyc++;

    // stimulus state
    logic s_iv, s_r1u, s_r2u, s_rdu;
    logic [4:0] s_r1, s_r2, s_rd;
    logic req_v [N];
    logic [4:0] req_rd [N];
    logic [DW-1:0] req_dat [N];
    bit last_issue;
    bit random_mode;

    // reference model
    bit [31:0] busy_m;
    bit clr_v;
    bit [4:0] clr_a;
    int rr_p;
    int wait_c [N];
    int pool [$];
    wr_t exp_q [$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        busy_m = '0;
        clr_v  = 1'b0;
        rr_p   = 0;
        exp_q.delete();
        pool.delete();
        for (int i = 0; i < N; i++) begin
            wait_c[i] = 0;
            req_v[i]  = 1'b0;
        end
    endtask

    task automatic drive();
        bus.id_valid    = s_iv;
        bus.id_rs1_use  = s_r1u;
        bus.id_rs2_use  = s_r2u;
        bus.id_rd_use   = s_rdu;
        bus.id_rs1_addr = s_r1;
        bus.id_rs2_addr = s_r2;
        bus.id_rd_addr  = s_rd;
        for (int i = 0; i < N; i++) begin
            bus.wb_valid[i]         = req_v[i];
            bus.wb_rd[i*5 +: 5]     = req_rd[i];
            bus.wb_data[i*DW +: DW] = req_dat[i];
        end
    endtask

    task automatic cycle();
        bit es, ei;
        int g;
        logic [N-1:0] er;
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        es = s_iv && ((s_r1u && busy_m[s_r1]) || (s_r2u && busy_m[s_r2]) || (s_rdu && busy_m[s_rd]));
        ei = s_iv && !es;
        chk("id_stall", bus.id_stall, es);
        chk("id_issue", bus.id_issue, ei);
        g = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                int idx;
`ifdef CORE_WB_RR_EN
                idx = (rr_p + k) % N;
`else
                idx = k;
`endif
                if (g < 0 && req_v[idx]) g = idx;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("wb_ready", bus.wb_ready, er);
`ifdef CORE_WB_RR_EN
        for (int i = 0; i < N; i++) begin
            if (req_v[i] && !bus.wb_ready[i]) wait_c[i]++;
            else wait_c[i] = 0;
            if (req_v[i]) chk("rr_wait_bound", (wait_c[i] <= N - 1), 1'b1);
        end
`endif
        last_issue = ei;
        if (!rst) begin
            if (clr_v) busy_m[clr_a] = 1'b0;
            if (ei && s_rdu && s_rd != 0) begin
                busy_m[s_rd] = 1'b1;
                if (random_mode) pool.push_back(int'(s_rd));
            end
            clr_v = 1'b0;
            if (g >= 0) begin
                if (req_rd[g] != 0) begin
                    exp_q.push_back('{a: req_rd[g], d: req_dat[g], due: cyc + 1});
                    clr_v = 1'b1;
                    clr_a = req_rd[g];
                end
`ifdef CORE_WB_RR_EN
                rr_p = (g + 1) % N;
`endif
                req_v[g] = 1'b0;
            end
        end
    endtask

    // Monitor: every registered write must match the oldest expected write, on time.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #2;
            if (bus.rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("rf_we_unexpected", bus.rf_we, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rf_addr", bus.rf_addr, e.a);
                    chk("rf_data", bus.rf_data, e.d);
                    chk("rf_timing", cyc, e.due);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                chk("rf_we_missing", bus.rf_we, 1'b1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic set_id(input logic iv, input logic r1u, input logic [4:0] r1,
                          input logic r2u, input logic [4:0] r2, input logic rdu, input logic [4:0] rd);
        s_iv = iv; s_r1u = r1u; s_r1 = r1; s_r2u = r2u; s_r2 = r2; s_rdu = rdu; s_rd = rd;
    endtask

    task automatic set_req(input int i, input logic [4:0] rd, input logic [DW-1:0] d);
        req_v[i] = 1'b1; req_rd[i] = rd; req_dat[i] = d;
    endtask

    logic [N-1:0] exp3 [3];
    logic [N-1:0] exp4 [6];

    initial begin
`ifdef CORE_WB_RR_EN
        exp3 = '{3'b010, 3'b100, 3'b001};
        exp4 = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
`else
        exp3 = '{3'b001, 3'b010, 3'b100};
        exp4 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
        random_mode = 1'b0;
        last_issue  = 1'b1;
        for (int i = 0; i < N; i++) begin req_rd[i] = '0; req_dat[i] = '0; end
        model_reset();
        set_id(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        drive();
        bus.wb_valid = '1;
        repeat (2) @(negedge clk);
        chk("rst_rf_we", bus.rf_we, 1'b0);
        chk("rst_rf_addr", bus.rf_addr, 5'd0);
        chk("rst_rf_data", bus.rf_data, 32'd0);
        chk("rst_wb_ready", bus.wb_ready, 3'b000);
        chk("rst_stall", bus.id_stall, 1'b0);
        #1 rst = 1'b0;

        // 1: RAW stall and its release after writeback
        set_id(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5);
        cycle();
        set_id(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        cycle();
        chk("t1_stall", bus.id_stall, 1'b1);
        set_req(WB_REQ_EXU, 5'd5, 32'hA5);
        cycle();
        cycle();
        chk("t1_rf_we", bus.rf_we, 1'b1);
        chk("t1_rf_addr", bus.rf_addr, 5'd5);
        chk("t1_rf_data", bus.rf_data, 32'hA5);
        chk("t1_stall_hold", bus.id_stall, 1'b1);
        cycle();
        chk("t1_stall_drop", bus.id_stall, 1'b0);

        // 2: x0 never stalls, x0 writeback never writes
        set_id(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0);
        cycle();
        set_id(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
        cycle();
        chk("t2_x0_stall", bus.id_stall, 1'b0);
        s_iv = 1'b0;
        set_req(WB_REQ_LSU, 5'd0, 32'h55);
        cycle();
        cycle();
        chk("t2_x0_rf_we", bus.rf_we, 1'b0);

        // 3: all three requesters contend
        for (int i = 0; i < N; i++) set_req(i, 5'(10 + i), DW'($urandom));
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t3_grant", bus.wb_ready, exp3[k]);
        end

        // 4: continuous contention, granted requester re-presents a new rd
        for (int i = 0; i < N; i++) set_req(i, 5'(20 + i), DW'($urandom));
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("t4_grant", bus.wb_ready, exp4[k]);
            for (int i = 0; i < N; i++)
                if (!req_v[i]) set_req(i, 5'(24 + k), DW'($urandom));
        end
        repeat (3) cycle();

        // 5: WAW stall, then same-edge set of 8 and clear of 7
        set_id(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
        cycle();
        cycle();
        chk("t5_waw_stall", bus.id_stall, 1'b1);
        set_req(WB_REQ_MDU, 5'd7, 32'h77);
        cycle();
        cycle();
        chk("t5_waw_hold", bus.id_stall, 1'b1);
        cycle();
        chk("t5_waw_issue", bus.id_issue, 1'b1);
        s_iv = 1'b0;
        set_req(WB_REQ_MDU, 5'd7, 32'h78);
        cycle();
        set_id(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8);
        cycle();
        chk("t5_issue8", bus.id_issue, 1'b1);
        set_id(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
        cycle();
        chk("t5_clr7", bus.id_stall, 1'b0);
        set_id(1'b1, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 5'd0);
        cycle();
        chk("t5_set8", bus.id_stall, 1'b1);

        // 6: reset while busy[3] is set and writes are in flight
        set_id(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3);
        cycle();
        set_id(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        set_req(WB_REQ_LSU, 5'd3, 32'h33);
        cycle();
        set_req(WB_REQ_EXU, 5'd9, 32'h99);
        cycle();
        chk("t6_rf_we_before", bus.rf_we, 1'b1);
        #3 rst = 1'b1;
        model_reset();
        #1;
        chk("t6_rf_we", bus.rf_we, 1'b0);
        chk("t6_stall", bus.id_stall, 1'b0);
        chk("t6_ready", bus.wb_ready, 3'b000);
        repeat (2) cycle();
        #1 rst = 1'b0;
        repeat (4) cycle();
        chk("t6_no_write", bus.rf_we, 1'b0);

        // random traffic
        random_mode = 1'b1;
        last_issue  = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!s_iv || last_issue)
                set_id($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom_range(0, 31)),
                       1'($urandom), 5'($urandom_range(0, 31)), 1'($urandom), 5'($urandom_range(0, 23)));
            for (int i = 0; i < N; i++) begin
                if (!req_v[i] && $urandom_range(0, 2) == 0) begin
                    int r;
                    r = $urandom_range(0, 9);
                    if (r < 6 && pool.size() > 0) begin
                        int k;
                        k = $urandom_range(0, pool.size() - 1);
                        set_req(i, 5'(pool[k]), DW'($urandom));
                        pool.delete(k);
                    end else if (r < 8) begin
                        set_req(i, 5'(24 + $urandom_range(0, 7)), DW'($urandom));
                    end else begin
                        set_req(i, 5'd0, DW'($urandom));
                    end
                end
            end
            cycle();
        end
        s_iv = 1'b0;
        repeat (10) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
